// File: rtl/misaligned_access_unit_pkg.sv
// misaligned_access_unit_pkg: funct3 codes and FSM state encodings shared by the misaligned access unit
package misaligned_access_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, LD_WB, ST_LO, ST_HI, ERR} state_t;
endpackage

// File: rtl/misaligned_access_unit_merge.sv
// misaligned_merge: combinational load merge/extend (f3, off, w_lo, w_hi -> ld_data) and store split (f3, off, store_value -> st_data, st_mask)
module misaligned_merge
  import misaligned_access_unit_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] w_lo,
  input  logic [23:0] w_hi,
  input  logic [31:0] store_value,
  output logic [31:0] ld_data,
  output logic [63:0] st_data,
  output logic [7:0]  st_mask
);
  logic [31:0] merged;
  assign merged = off == 2'd1 ? {w_hi[7:0], w_lo[31:8]} :
                  off == 2'd2 ? {w_hi[15:0], w_lo[31:16]} :
                  off == 2'd3 ? {w_hi, w_lo[31:24]} : w_lo;
  assign ld_data = f3 == F3_LH  ? {{16{merged[15]}}, merged[15:0]} :
                   f3 == F3_LHU ? {16'b0, merged[15:0]} : merged;
  assign st_data = {32'b0, store_value} << {off, 3'b000};
  assign st_mask = {4'b0, f3 == F3_SH ? 4'b0011 : 4'b1111} << off;
endmodule

// File: rtl/misaligned_access_unit.sv
// misaligned_access_unit: performs a trapped misaligned LH/LHU/LW/SH/SW as two aligned word accesses; ports: start/instr/is_store/addr/store_value/rd_addr request, mem_* data memory, rf_* writeback, busy/done/error status
module misaligned_access_unit
  import misaligned_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           instr,
  input  logic                  is_store,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_value,
  input  logic [4:0]            rd_addr,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  state_t state, next;
  logic [2:0] f3;
  logic [ADDR_WIDTH-1:0] addr_q, lo, hi;
  logic [31:0] sv_q, w_lo, ld_data;
  logic [4:0] rd_q;
  logic [63:0] st_data;
  logic [7:0] st_mask;
  logic valid, unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:0]};
  assign valid = is_store ?
    (instr[14:12] == F3_SH && addr[1:0] == 2'd3) || (instr[14:12] == F3_SW && addr[1:0] != 2'd0) :
    ((instr[14:12] == F3_LH || instr[14:12] == F3_LHU) && addr[1:0] == 2'd3) || (instr[14:12] == F3_LW && addr[1:0] != 2'd0);
  assign lo = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign hi = lo + ADDR_WIDTH'(4);
  misaligned_merge u_merge (
    .f3          (f3),
    .off         (addr_q[1:0]),
    .w_lo        (w_lo),
    .w_hi        (mem_rdata[23:0]),
    .store_value (sv_q),
    .ld_data     (ld_data),
    .st_data     (st_data),
    .st_mask     (st_mask)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f3 <= 3'b0;
      addr_q <= '0;
      sv_q <= 32'b0;
      rd_q <= 5'b0;
      w_lo <= 32'b0;
    end else begin
      if (state == IDLE && start) begin
        f3 <= instr[14:12];
        addr_q <= addr;
        sv_q <= store_value;
        rd_q <= rd_addr;
      end
      if (state == LD_HI) w_lo <= mem_rdata;
    end
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = !start ? IDLE : !valid ? ERR : is_store ? ST_LO : LD_LO;
      LD_LO:   next = LD_HI;
      LD_HI:   next = LD_WB;
      ST_LO:   next = ST_HI;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    mem_en = state inside {LD_LO, LD_HI, ST_LO, ST_HI};
    mem_addr = state inside {LD_LO, ST_LO} ? lo : mem_en ? hi : '0;
    mem_we = state == ST_LO ? st_mask[3:0] : state == ST_HI ? st_mask[7:4] : 4'b0;
    mem_wdata = state == ST_LO ? st_data[31:0] : state == ST_HI ? st_data[63:32] : 32'b0;
    rf_we = state == LD_WB && rd_q != 5'd0;
    rf_waddr = state == LD_WB ? rd_q : 5'd0;
    rf_wdata = state == LD_WB ? ld_data : 32'b0;
    busy = state != IDLE;
    done = state inside {LD_WB, ST_HI, ERR};
    error = state == ERR;
  end
endmodule

// File: tb/tb_misaligned_access_unit.sv
// tb_misaligned_access_unit: byte-level memory model checks of the misaligned access unit
module tb_misaligned_access_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_store = 1'b0;
  logic [31:0] instr = 32'b0, store_value = 32'b0, mem_rdata = 32'b0;
  logic [14:0] addr = 15'b0;
  logic [4:0] rd_addr = 5'b0;
  logic mem_en, rf_we, busy, done, error;
  logic [3:0] mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata, rf_wdata;
  logic [4:0] rf_waddr;
  int total = 0, bad = 0;
  logic [7:0] mem [0:32767];
  logic chk = 1'b0;
  logic e_mem_en, e_rf_we, e_busy, e_done, e_error;
  logic [3:0] e_mem_we;
  logic [14:0] e_mem_addr;
  logic [31:0] e_mem_wdata, e_rf_wdata;
  logic [4:0] e_rf_waddr;
  logic [2:0] r_f3;
  logic r_st, r_valid;
  logic [14:0] r_a;
  logic [31:0] r_sv, r_lv;
  logic [4:0] r_rd;
  logic [31:0] got_ma [0:5];
  logic [31:0] got_we [0:5];
  logic [31:0] got_wd [0:5];
  logic [31:0] got_rf;

  always #5 clk = ~clk;

  misaligned_access_unit #(.ADDR_WIDTH(15)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .is_store(is_store),
    .addr(addr), .store_value(store_value), .rd_addr(rd_addr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we == 4'b0)
        mem_rdata <= {mem[int'(mem_addr) + 3], mem[int'(mem_addr) + 2], mem[int'(mem_addr) + 1], mem[int'(mem_addr)]};
      else
        for (int j = 0; j < 4; j++)
          if (mem_we[j]) mem[int'(mem_addr) + j] = mem_wdata[8*j +: 8];
    end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk) begin
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("done", 32'(done), 32'(e_done));
      cmp("error", 32'(error), 32'(e_error));
      cmp("mem_en", 32'(mem_en), 32'(e_mem_en));
      cmp("mem_we", 32'(mem_we), 32'(e_mem_we));
      cmp("rf_we", 32'(rf_we), 32'(e_rf_we));
      if (e_mem_en) cmp("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
      if (e_mem_we != 4'b0) cmp("mem_wdata", mem_wdata, e_mem_wdata);
      if (e_rf_we) begin
        cmp("rf_waddr", 32'(rf_waddr), 32'(e_rf_waddr));
        cmp("rf_wdata", rf_wdata, e_rf_wdata);
      end
    end

  function automatic logic model_valid(input logic [2:0] f3, input logic st, input logic [1:0] off);
    if (st) return (f3 == 3'b001 && off == 2'd3) || (f3 == 3'b010 && off != 2'd0);
    return ((f3 == 3'b001 || f3 == 3'b101) && off == 2'd3) || (f3 == 3'b010 && off != 2'd0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [14:0] a);
    logic [31:0] v;
    for (int j = 0; j < 4; j++) v[8*j +: 8] = mem[(int'(a) + j) & 32'h7FFF];
    if (f3 == 3'b001) return {{16{v[15]}}, v[15:0]};
    if (f3 == 3'b101) return {16'b0, v[15:0]};
    return v;
  endfunction

  task automatic set_exp(input int k, input int n);
    int off, p, sz, wo;
    e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
    e_rf_we = 0; e_rf_waddr = 0; e_rf_wdata = 0; e_busy = 0; e_done = 0; e_error = 0;
    if (k < 1 || k > n) return;
    e_busy = 1;
    e_done = (k == n);
    off = int'(r_a[1:0]);
    wo = 4 * (k - 1);
    if (!r_valid) e_error = 1;
    else if (!r_st) begin
      if (k < 3) begin
        e_mem_en = 1;
        e_mem_addr = 15'((int'(r_a) - off + wo) & 32'h7FFF);
      end else begin
        e_rf_we = r_rd != 5'd0;
        e_rf_waddr = r_rd;
        e_rf_wdata = r_lv;
      end
    end else begin
      sz = r_f3 == 3'b001 ? 2 : 4;
      e_mem_en = 1;
      e_mem_addr = 15'((int'(r_a) - off + wo) & 32'h7FFF);
      for (int j = 0; j < 4; j++) begin
        p = wo + j - off;
        if (p >= 0 && p < sz) e_mem_we[j] = 1'b1;
        if (p >= 0 && p < 4) e_mem_wdata[8*j +: 8] = r_sv[8*p +: 8];
      end
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic st, input logic [14:0] a, input logic [31:0] sv, input logic [4:0] rd);
    instr = $urandom();
    instr[14:12] = f3;
    instr[6:0] = st ? 7'h23 : 7'h03;
    is_store = st;
    addr = a;
    store_value = sv;
    rd_addr = rd;
  endtask

  task automatic run_req(input logic [2:0] f3, input logic st, input logic [14:0] a, input logic [31:0] sv, input logic [4:0] rd, input int poke);
    int n;
    r_f3 = f3; r_st = st; r_a = a; r_sv = sv; r_rd = rd;
    r_valid = model_valid(f3, st, a[1:0]);
    r_lv = model_load(f3, a);
    n = !r_valid ? 1 : st ? 2 : 3;
    got_rf = 32'hDEADBEEF;
    for (int k = 0; k <= n + 1; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (k == poke);
      if (k == 0) drive(f3, st, a, sv, rd);
      else if (k == poke) drive(3'b010, 1'b1, 15'h0401, 32'hFFFFFFFF, 5'd3);
      set_exp(k, n);
      chk = 1'b1;
      @(negedge clk);
      got_ma[k] = 32'(mem_addr);
      got_we[k] = 32'(mem_we);
      got_wd[k] = mem_wdata;
      if (done) got_rf = rf_wdata;
    end
    start = 1'b0;
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) mem[a + j] = w[8*j +: 8];
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    set_word(32'h0100, 32'hDDCCBBAA);
    set_word(32'h0104, 32'h44332211);
    set_word(32'h0200, 32'h80123456);
    set_word(32'h0204, 32'h9ABCDEF1);
    set_word(32'h0400, 32'h76543210);
    set_word(32'h0404, 32'hFEDCBA98);
    #2;
    cmp("rst_mem_en", 32'(mem_en), 32'd0);
    cmp("rst_mem_we", 32'(mem_we), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_error", 32'(error), 32'd0);
    cmp("rst_rf_we", 32'(rf_we), 32'd0);
    cmp("rst_rf_wdata", rf_wdata, 32'd0);
    #10 rst = 1'b0;
    run_req(3'b010, 1'b0, 15'h0102, 32'h0, 5'd5, -1);
    cmp("lw_lit", got_rf, 32'h2211DDCC);
    run_req(3'b001, 1'b0, 15'h0203, 32'h0, 5'd6, -1);
    cmp("lh_lit", got_rf, 32'hFFFFF180);
    run_req(3'b101, 1'b0, 15'h0203, 32'h0, 5'd6, -1);
    cmp("lhu_lit", got_rf, 32'h0000F180);
    run_req(3'b010, 1'b1, 15'h0301, 32'hA1B2C3D4, 5'd0, -1);
    cmp("sw_c1_addr", got_ma[1], 32'h0300);
    cmp("sw_c1_we", got_we[1], 32'b1110);
    cmp("sw_c1_wd", got_wd[1], 32'hB2C3D400);
    cmp("sw_c2_addr", got_ma[2], 32'h0304);
    cmp("sw_c2_we", got_we[2], 32'b0001);
    cmp("sw_c2_wd", got_wd[2], 32'h000000A1);
    cmp("sw_mem_below", 32'(mem[32'h0300]), 32'h00);
    for (int j = 0; j < 4; j++) cmp("sw_mem_byte", 32'(mem[32'h0301 + j]), 32'(r_sv[8*j +: 8]));
    cmp("sw_mem_above", 32'(mem[32'h0305]), 32'h00);
    run_req(3'b010, 1'b0, 15'h0301, 32'h0, 5'd9, -1);
    cmp("sw_readback", got_rf, 32'hA1B2C3D4);
    run_req(3'b001, 1'b1, 15'h7FFF, 32'h0000BEEF, 5'd0, -1);
    cmp("sh_c1_addr", got_ma[1], 32'h7FFC);
    cmp("sh_c1_we", got_we[1], 32'b1000);
    cmp("sh_c2_addr", got_ma[2], 32'h0000);
    cmp("sh_c2_we", got_we[2], 32'b0001);
    cmp("sh_mem_lo", 32'(mem[32'h7FFF]), 32'hEF);
    cmp("sh_mem_hi", 32'(mem[32'h0000]), 32'hBE);
    cmp("sh_mem_next", 32'(mem[32'h0001]), 32'h00);
    run_req(3'b010, 1'b0, 15'h0010, 32'h0, 5'd4, -1);
    run_req(3'b000, 1'b0, 15'h0013, 32'h0, 5'd4, -1);
    run_req(3'b001, 1'b0, 15'h0401, 32'h0, 5'd4, -1);
    run_req(3'b011, 1'b0, 15'h0403, 32'h0, 5'd4, -1);
    run_req(3'b001, 1'b1, 15'h0402, 32'h1234, 5'd0, -1);
    run_req(3'b000, 1'b1, 15'h0403, 32'h55, 5'd0, -1);
    run_req(3'b101, 1'b1, 15'h0403, 32'h55, 5'd0, -1);
    run_req(3'b010, 1'b0, 15'h0401, 32'h0, 5'd17, -1);
    run_req(3'b010, 1'b0, 15'h0403, 32'h0, 5'd31, -1);
    run_req(3'b101, 1'b0, 15'h0403, 32'h0, 5'd2, -1);
    run_req(3'b010, 1'b1, 15'h0402, 32'hCAFEF00D, 5'd0, -1);
    run_req(3'b010, 1'b0, 15'h0402, 32'h0, 5'd8, -1);
    cmp("sw_off2_readback", got_rf, 32'hCAFEF00D);
    run_req(3'b010, 1'b0, 15'h0102, 32'h0, 5'd0, -1);
    run_req(3'b010, 1'b0, 15'h0102, 32'h0, 5'd10, 2);
    run_req(3'b010, 1'b1, 15'h0501, 32'h11223344, 5'd0, 2);
    run_req(3'b001, 1'b0, 15'h0203, 32'h0, 5'd11, 3);
    chk = 1'b0;
    @(posedge clk); #1;
    drive(3'b010, 1'b0, 15'h0102, 32'h0, 5'd12);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmp("pre_rst_lo", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    cmp("pre_rst_hi_addr", 32'(mem_addr), 32'h0104);
    #2 rst = 1'b1;
    #1;
    cmp("arst_mem_en", 32'(mem_en), 32'd0);
    cmp("arst_mem_addr", 32'(mem_addr), 32'd0);
    cmp("arst_busy", 32'(busy), 32'd0);
    cmp("arst_done", 32'(done), 32'd0);
    cmp("arst_rf_we", 32'(rf_we), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    set_exp(0, 0);
    chk = 1'b1;
    run_req(3'b010, 1'b0, 15'h0102, 32'h0, 5'd13, -1);
    cmp("post_rst_lw", got_rf, 32'h2211DDCC);
    @(posedge clk); #1;
    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/misaligned_access_unit.md
Name: misaligned_access_unit

Overview:
- Hardware handler for misaligned data accesses; it consumes the trap record the CSR unit captures on a misalignment.
- The trap record holds the instruction word, the 15-bit byte address, and the store value or rd index.
- The block performs the access as two aligned word transactions on data memory. Loads are merged and written back to the register file; stores are split into byte-masked writes.
- Sits beside the CSR unit and data memory. `done` tells the core to resume at mepc+4.

Parameters:
- ADDR_WIDTH, 15, byte address width of data memory; the word address is ADDR_WIDTH-2 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- instr  in  32  trapping instruction word; funct3 = instr[14:12]
- is_store  in  1  1 = store, 0 = load
- addr  in  ADDR_WIDTH  misaligned byte address
- store_value  in  32  store data (stores only)
- rd_addr  in  5  load destination register
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables (0000 = read)
- mem_addr  out  ADDR_WIDTH  word-aligned byte address, bits [1:0] = 00
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we=0
- rf_we  out  1  register file write strobe
- rf_waddr  out  5  register file write index
- rf_wdata  out  32  register file write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse: request not a misaligned access

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; all outputs 0; internal registers cleared.
- Reset during ST_HI: the lower word is already written; no rollback is performed.
- On accepted start, latch instr[14:12], is_store, addr, store_value, rd_addr.
- Offset and word addresses:
  - off = addr[1:0]
  - lo = {addr[AW-1:2],00}
  - hi = lo + 4 modulo 2^ADDR_WIDTH, so 0x7FFC wraps to 0x0000.
- Valid requests:
  - Loads: LH, LHU (funct3 001/101) with off = 3; LW (010) with off != 0.
  - Stores: SH (001) with off = 3; SW (010) with off != 0.
- Any other combination (aligned access, byte access, reserved funct3):
  - IDLE -> ERR for one cycle; error = 1, done = 1.
  - No memory or register file activity.
- Load states:
  - IDLE -> LD_LO: mem_en = 1, mem_addr = lo, mem_we = 0.
  - LD_LO -> LD_HI: mem_en = 1, mem_addr = hi; capture mem_rdata as w_lo.
  - LD_HI -> LD_WB: capture mem_rdata as w_hi; merged = {w_hi, w_lo} >> (8*off).
  - LW result = merged[31:0]. LH sign-extends merged[15:0]; LHU zero-extends it.
  - LD_WB: rf_we = 1 unless rd_addr = 0; rf_waddr = rd_addr; done = 1; -> IDLE.
  - Latency: start in cycle 0, writeback and done in cycle 3.
- Store states:
  - Compute d = {32'b0, store_value} << (8*off).
  - Compute m = ({4'b0, SH ? 0011 : 1111}) << off.
  - IDLE -> ST_LO: mem_en = 1, mem_addr = lo, mem_we = m[3:0], mem_wdata = d[31:0].
  - ST_LO -> ST_HI: mem_en = 1, mem_addr = hi, mem_we = m[7:4], mem_wdata = d[63:32]; done = 1; -> IDLE.
  - Latency: done in cycle 2.
- Request handling:
  - start while busy is ignored; there is no queueing.
  - start coincident with done's cycle is ignored; the earliest new request is accepted the cycle after done.
- mem_we is 0000 whenever mem_en = 0.
- rf_we, done and error are single-cycle pulses.

Decomposition:
- Shared common library holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - FSM state encodings IDLE, LD_LO, LD_HI, LD_WB, ST_LO, ST_HI, ERR.
- One natural sub-module, misaligned_merge: purely combinational.
  - Load path: {w_hi, w_lo}, off and funct3 -> extended load result.
  - Store path: store_value, off and funct3 -> d and m.
  - The FSM stays in the top.

Test Plan:
- LW, addr = 0x0102, mem[0x0100] = 0xDDCCBBAA, mem[0x0104] = 0x44332211, rd = 5 -> cycle 3: rf_we = 1, rf_waddr = 5, rf_wdata = 0x2211DDCC, done = 1.
- LH, addr = 0x0203, mem[0x0200] = 0x80xxxxxx, mem[0x0204] = 0xxxxxxxF1 -> rf_wdata = 0xFFFFF180; LHU same data -> 0x0000F180.
- SW 0xA1B2C3D4, addr = 0x0301:
  - cycle 1: mem_addr = 0x0300, mem_we = 1110, mem_wdata = 0xB2C3D400.
  - cycle 2: mem_addr = 0x0304, mem_we = 0001, mem_wdata = 0x000000A1, done = 1.
- SH 0xBEEF, addr = 0x7FFF -> writes 0x7FFC with mem_we = 1000 (byte 0xEF), then wrap address 0x0000 with mem_we = 0001 (byte 0xBE).
- LW addr = 0x0010 (aligned) and LB addr = 0x0013 -> error = 1, done = 1 for one cycle, mem_en never asserted, rf_we stays 0.
- Mid-operation and corner cases:
  - LW with rd = 0 -> done without rf_we.
  - start during LD_HI -> ignored.
  - rst asserted in LD_HI -> all outputs 0 immediately; next start is accepted normally.
